// File: rtl/fixed_residual_calculator.sv
// FLAC fixed-predictor residual calculator, orders 0..4, one block of samples at a time.
// Samples are accepted in RUN. Stage 1 registers the sample and the scaled history terms.
// Stage 2 registers two partial sums. The output register holds the final residual.
// Result: a sample accepted at edge t is driven on the outputs after edge t+2.
module fixed_residual_calculator #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned RES_W    = 20,
    parameter int unsigned BS_W     = 16
) (
    input  logic                iClock,
    input  logic                iReset_n,
    input  logic                iStart,
    input  logic [2:0]          iOrder,
    input  logic [BS_W-1:0]     iBlockSize,
    input  logic                iValid,
    input  logic [SAMPLE_W-1:0] iSample,
    output logic                oValid,
    output logic [RES_W-1:0]    oResidual,
    output logic                oWarmup,
    output logic                oLast,
    output logic                oBusy
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e r_state, w_state_next;

    logic [2:0]          r_order;
    logic [BS_W-1:0]     r_bsize;
    logic [BS_W-1:0]     r_n;
    logic [SAMPLE_W-1:0] r_x1, r_x2, r_x3, r_x4;

    // Stage 1: sample plus signed, scaled history terms
    logic                    r_s1_valid, r_s1_warm, r_s1_last;
    logic signed [RES_W-1:0] r_s1_x, r_s1_t1, r_s1_t2, r_s1_t3, r_s1_t4;
    // Stage 2: partial sums
    logic                    r_s2_valid, r_s2_warm, r_s2_last;
    logic signed [RES_W-1:0] r_s2_a, r_s2_b;
    // Output register
    logic                    r_out_valid, r_out_warm, r_out_last;
    logic [RES_W-1:0]        r_out_res;

    logic                    w_start_ok, w_accept, w_warm, w_last;
    logic signed [RES_W-1:0] w_x, w_h1, w_h2, w_h3, w_h4;
    logic signed [RES_W-1:0] w_t1, w_t2, w_t3, w_t4;

    assign w_start_ok = (r_state == StIdle) && iStart && (iOrder <= 3'd4) &&
                        (iBlockSize != '0);
    assign w_accept   = (r_state == StRun) && iValid;
    assign w_warm     = r_n < {{(BS_W-3){1'b0}}, r_order};
    assign w_last     = r_n == (r_bsize - 1'b1);

    // Sign-extend sample and history to full residual width before any arithmetic
    assign w_x  = {{(RES_W-SAMPLE_W){iSample[SAMPLE_W-1]}}, iSample};
    assign w_h1 = {{(RES_W-SAMPLE_W){r_x1[SAMPLE_W-1]}}, r_x1};
    assign w_h2 = {{(RES_W-SAMPLE_W){r_x2[SAMPLE_W-1]}}, r_x2};
    assign w_h3 = {{(RES_W-SAMPLE_W){r_x3[SAMPLE_W-1]}}, r_x3};
    assign w_h4 = {{(RES_W-SAMPLE_W){r_x4[SAMPLE_W-1]}}, r_x4};

    // Binomial history terms for the latched order; all zero for warm-up samples
    always_comb begin
        w_t1 = '0;
        w_t2 = '0;
        w_t3 = '0;
        w_t4 = '0;
        if (!w_warm) begin
            case (r_order)
                3'd1: w_t1 = -w_h1;
                3'd2: begin
                    w_t1 = -(w_h1 <<< 1);
                    w_t2 = w_h2;
                end
                3'd3: begin
                    w_t1 = -((w_h1 <<< 1) + w_h1);
                    w_t2 = (w_h2 <<< 1) + w_h2;
                    w_t3 = -w_h3;
                end
                3'd4: begin
                    w_t1 = -(w_h1 <<< 2);
                    w_t2 = (w_h2 <<< 2) + (w_h2 <<< 1);
                    w_t3 = -(w_h3 <<< 2);
                    w_t4 = w_h4;
                end
                default: ;
            endcase
        end
    end

    // Block control state register
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) r_state <= StIdle;
        else           r_state <= w_state_next;
    end

    // Next-state: leave DRAIN once the final output is on the port
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_start_ok) w_state_next = StRun;
            StRun:   if (w_accept && w_last) w_state_next = StDrain;
            StDrain: if (r_out_valid && r_out_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Block parameters, sample count and history shift register
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_order <= '0;
            r_bsize <= '0;
            r_n     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_x3    <= '0;
            r_x4    <= '0;
        end else if (w_start_ok) begin
            r_order <= iOrder;
            r_bsize <= iBlockSize;
            r_n     <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_x3    <= '0;
            r_x4    <= '0;
        end else if (w_accept) begin
            r_n  <= r_n + 1'b1;
            r_x1 <= iSample;
            r_x2 <= r_x1;
            r_x3 <= r_x2;
            r_x4 <= r_x3;
        end
    end

    // Three register levels: terms, partial sums, output
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_warm   <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_x      <= '0;
            r_s1_t1     <= '0;
            r_s1_t2     <= '0;
            r_s1_t3     <= '0;
            r_s1_t4     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_warm   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_a      <= '0;
            r_s2_b      <= '0;
            r_out_valid <= 1'b0;
            r_out_warm  <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_res   <= '0;
        end else begin
            r_s1_valid  <= w_accept;
            r_s1_warm   <= w_accept && w_warm;
            r_s1_last   <= w_accept && w_last;
            r_s1_x      <= w_x;
            r_s1_t1     <= w_t1;
            r_s1_t2     <= w_t2;
            r_s1_t3     <= w_t3;
            r_s1_t4     <= w_t4;
            r_s2_valid  <= r_s1_valid;
            r_s2_warm   <= r_s1_warm;
            r_s2_last   <= r_s1_last;
            r_s2_a      <= r_s1_x + r_s1_t1;
            r_s2_b      <= r_s1_t2 + r_s1_t3 + r_s1_t4;
            r_out_valid <= r_s2_valid;
            r_out_warm  <= r_s2_valid && r_s2_warm;
            r_out_last  <= r_s2_valid && r_s2_last;
            // Residual holds its last value across bubbles
            if (r_s2_valid) r_out_res <= r_s2_a + r_s2_b;
        end
    end

    assign oValid    = r_out_valid;
    assign oResidual = r_out_res;
    assign oWarmup   = r_out_warm;
    assign oLast     = r_out_last;
    assign oBusy     = (r_state != StIdle);

endmodule

// File: tb/tb_fixed_residual_calculator.sv
// Self-checking bench for fixed_residual_calculator: directed steps plus random blocks,
// compared against a binomial-coefficient reference model.
module tb_fixed_residual_calculator;

    localparam int DEPTH = 4096;

    logic        iClock, iReset_n, iStart, iValid;
    logic [2:0]  iOrder;
    logic [15:0] iBlockSize, iSample;
    logic        oValid, oWarmup, oLast, oBusy;
    logic [19:0] oResidual;

    fixed_residual_calculator dut (
        .iClock     (iClock),
        .iReset_n   (iReset_n),
        .iStart     (iStart),
        .iOrder     (iOrder),
        .iBlockSize (iBlockSize),
        .iValid     (iValid),
        .iSample    (iSample),
        .oValid     (oValid),
        .oResidual  (oResidual),
        .oWarmup    (oWarmup),
        .oLast      (oLast),
        .oBusy      (oBusy)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected outputs indexed by the edge after which they are visible
    bit exp_v [DEPTH];
    bit exp_w [DEPTH];
    bit exp_l [DEPTH];
    bit exp_b [DEPTH];
    int exp_r [DEPTH];
    int m_hold = 0;

    // Reference model of the block
    bit m_active = 0;
    bit m_accepting = 0;
    int m_order = 0;
    int m_bs = 0;
    int m_end = 0;
    int xs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc,
                   $signed(obs), $signed(expv));
        end
    endtask

    function automatic int residual(input int n, input int ord);
        int e = 0;
        int c = 1;
        for (int j = 0; j <= ord; j++) begin
            e += ((j % 2) ? -c : c) * xs[n-j];
            c = c * (ord - j) / (j + 1);
        end
        return e;
    endfunction

    task automatic model_edge(input int e, input bit st, input int ord, input int bs,
                              input bit v, input int s);
        bit was_idle = !m_active;
        int n;
        if (m_active && !m_accepting && e == m_end + 1) m_active = 0;
        if (was_idle) begin
            if (st && ord <= 4 && bs != 0) begin
                m_active = 1;
                m_accepting = 1;
                m_order = ord;
                m_bs = bs;
                xs.delete();
            end
        end else if (m_accepting && v) begin
            n = xs.size();
            xs.push_back(s);
            if (e + 2 < DEPTH) begin
                exp_v[e+2] = 1;
                exp_w[e+2] = (n < m_order);
                exp_l[e+2] = (n == m_bs - 1);
                exp_r[e+2] = (n < m_order) ? s : residual(n, m_order);
            end
            if (n == m_bs - 1) begin
                m_accepting = 0;
                m_end = e + 2;
            end
        end
        if (e < DEPTH) exp_b[e] = m_active;
    endtask

    task automatic check_cycle();
        int i = (cyc < DEPTH) ? cyc : DEPTH - 1;
        if (exp_v[i]) m_hold = exp_r[i];
        chk("oValid", {31'b0, oValid}, {31'b0, exp_v[i]});
        chk("oWarmup", {31'b0, oWarmup}, {31'b0, exp_w[i]});
        chk("oLast", {31'b0, oLast}, {31'b0, exp_l[i]});
        chk("oBusy", {31'b0, oBusy}, {31'b0, exp_b[i]});
        chk("oResidual", {{12{oResidual[19]}}, oResidual}, m_hold);
    endtask

    task automatic step(input bit st, input int ord, input int bs, input bit v, input int s);
        iStart = st;
        iOrder = ord[2:0];
        iBlockSize = bs[15:0];
        iValid = v;
        iSample = s[15:0];
        @(posedge iClock);
        cyc++;
        model_edge(cyc, st, ord, bs, v, s);
        @(negedge iClock);
        check_cycle();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int guard = 0;
        while (m_active && guard < 40) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        chk("drain_timeout", {31'b0, m_active}, 32'd0);
    endtask

    task automatic do_reset();
        iReset_n = 1'b0;
        #1;
        chk("rst_oValid", {31'b0, oValid}, 32'd0);
        chk("rst_oBusy", {31'b0, oBusy}, 32'd0);
        chk("rst_oLast", {31'b0, oLast}, 32'd0);
        chk("rst_oResidual", {12'b0, oResidual}, 32'd0);
        for (int i = cyc + 1; i < DEPTH; i++) begin
            exp_v[i] = 0;
            exp_w[i] = 0;
            exp_l[i] = 0;
            exp_b[i] = 0;
        end
        m_hold = 0;
        m_active = 0;
        m_accepting = 0;
        xs.delete();
        iStart = 0;
        iValid = 0;
        @(posedge iClock);
        cyc++;
        @(negedge iClock);
        check_cycle();
        iReset_n = 1'b1;
    endtask

    task automatic run_random_block();
        int ord = $urandom_range(0, 4);
        int bs = $urandom_range(1, 12);
        int guard = 0;
        step(1, ord, bs, $urandom_range(0, 1), 123);
        while (m_accepting && guard < 200) begin
            step(($urandom_range(0, 7) == 0), $urandom_range(0, 7), $urandom_range(0, 20),
                 ($urandom_range(0, 9) < 7), int'($urandom_range(0, 65535)) - 32768);
            guard++;
        end
        drain();
        idle($urandom_range(0, 2));
    endtask

    initial begin
        iReset_n = 1'b0;
        iStart = 0;
        iOrder = 0;
        iBlockSize = 0;
        iValid = 0;
        iSample = 0;
        #3;
        chk("reset_oValid", {31'b0, oValid}, 32'd0);
        chk("reset_oBusy", {31'b0, oBusy}, 32'd0);
        chk("reset_oResidual", {12'b0, oResidual}, 32'd0);
        @(negedge iClock);
        iReset_n = 1'b1;
        idle(2);

        // Order 2 ramp: two warm-ups then zero residuals
        step(1, 2, 6, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 2, 6, 1, i * 10);
        drain();

        // Order 4 full-scale alternation
        step(1, 4, 8, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 4, 8, 1, (i % 2) ? -32768 : 32767);
        drain();

        // Order 1 with bubbles; iStart+iValid same cycle drops that sample
        step(1, 1, 4, 1, 99);
        step(0, 1, 4, 1, 5);
        step(0, 1, 4, 0, 0);
        step(0, 1, 4, 0, 0);
        step(0, 1, 4, 1, 7);
        step(0, 1, 4, 1, 4);
        step(0, 1, 4, 0, 0);
        step(0, 1, 4, 1, 9);
        drain();

        // Order 0 sign extension
        step(1, 0, 3, 0, 0);
        step(0, 0, 3, 1, -1);
        step(0, 0, 3, 1, 0);
        step(0, 0, 3, 1, 1);
        drain();

        // Rejected starts in IDLE, ignored start mid-run, valid in IDLE
        step(1, 5, 4, 1, 1);
        step(1, 2, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(1, 3, 4, 0, 0);
        step(0, 3, 4, 1, 100);
        step(1, 0, 1, 1, -200);
        step(0, 3, 4, 1, 300);
        step(1, 1, 2, 1, -400);
        step(0, 3, 4, 1, 555);
        drain();

        // Block shorter than order: all warm-up
        step(1, 4, 2, 0, 0);
        step(0, 4, 2, 1, -1234);
        step(0, 4, 2, 1, 4321);
        drain();

        // Reset mid-block, then history must be cleared for the next block
        step(1, 3, 8, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 3, 8, 1, 1000 + i);
        do_reset();
        idle(4);
        step(1, 3, 5, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 3, 5, 1, -50 * i + 7);
        drain();

        for (int b = 0; b < 40; b++) run_random_block();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
